// File: rtl/usart_tx_buffer.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1 serialiser, LSB first.
// Define USART_PARITY_EN to insert an even-parity bit before the stop bit (8E1).
module usart_tx_buffer #(
  parameter int CLOCK_DIV      = 139,
  parameter int FIFO_DEPTH     = 4,
  parameter int FIFO_ADDR_BITS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       write,
  input  logic [7:0] data_in,
  input  logic       clear_overflow,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       overflow,
  output logic       tx_pin
);

  localparam int TW = $clog2(CLOCK_DIV);
  localparam logic [TW-1:0] BIT_LOAD = TW'(CLOCK_DIV - 1);
  localparam logic [FIFO_ADDR_BITS:0] DEPTH = (FIFO_ADDR_BITS + 1)'(FIFO_DEPTH);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef USART_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  logic [7:0]                mem [FIFO_DEPTH];
  logic [FIFO_ADDR_BITS-1:0] wptr, rptr;
  logic [FIFO_ADDR_BITS:0]   count;
  logic                      accept, pop;

  logic [2:0]    state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_index;
  logic [7:0]    shift;
  logic          bit_done;
  logic          line;
`ifdef USART_PARITY_EN
  logic          parity_bit;
`endif

  assign empty    = (count == '0);
  assign full     = (count == DEPTH);
  assign busy     = (state != IDLE) || !empty;
  assign bit_done = (timer == '0);
  assign accept   = write && !full;
  // Pops happen from IDLE or on the last stop cycle, so frames chain with no gap.
  assign pop      = !empty && ((state == IDLE) || (state == STOP && bit_done));

  always_ff @(posedge clk) begin
    if (accept) mem[wptr] <= data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (accept) wptr <= wptr + 1'b1;
      if (pop)    rptr <= rptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Set beats clear when both land in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   overflow <= 1'b0;
    else if (write && full)      overflow <= 1'b1;
    else if (clear_overflow)     overflow <= 1'b0;
  end

  always_comb begin
    line = 1'b1;
    case (state)
      START:   line = 1'b0;
      DATA:    line = shift[0];
`ifdef USART_PARITY_EN
      PARITY:  line = parity_bit;
`endif
      default: line = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      bit_index <= '0;
      shift     <= '0;
      tx_pin    <= 1'b1;
`ifdef USART_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      tx_pin <= line;
      timer  <= (state == IDLE || bit_done) ? BIT_LOAD : timer - TW'(1);
      if (pop) begin
        shift <= mem[rptr];
`ifdef USART_PARITY_EN
        parity_bit <= ^mem[rptr];
`endif
      end
      case (state)
        IDLE: if (pop) state <= START;
        START: if (bit_done) begin
          state     <= DATA;
          bit_index <= '0;
        end
        DATA: if (bit_done) begin
          shift <= {1'b0, shift[7:1]};
          if (bit_index == 3'd7) begin
`ifdef USART_PARITY_EN
            state <= PARITY;
`else
            state <= STOP;
`endif
          end else begin
            bit_index <= bit_index + 3'd1;
          end
        end
`ifdef USART_PARITY_EN
        PARITY: if (bit_done) state <= STOP;
`endif
        STOP: if (bit_done) state <= pop ? START : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usart_tx_buffer.sv
// Bench for usart_tx_buffer: a line monitor decodes frames and checks them against
// a queue of expected bytes; scenario tasks check latency, flags and reset.
module tb_usart_tx_buffer;
  localparam int DIV = 4;
`ifdef USART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME = DIV * FRAME_BITS;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       write = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       clear_overflow = 1'b0;
  logic       full, empty, busy, overflow, tx_pin;

  usart_tx_buffer #(.CLOCK_DIV(DIV), .FIFO_DEPTH(4), .FIFO_ADDR_BITS(2)) dut (
    .clk(clk), .reset(reset), .write(write), .data_in(data_in),
    .clear_overflow(clear_overflow), .full(full), .empty(empty), .busy(busy),
    .overflow(overflow), .tx_pin(tx_pin)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  int         starts[$];
  bit         mon_en = 1'b0;
  bit         mon_busy = 1'b0;

  // Frame decoder: detects the first low cycle, then samples mid-bit.
  initial begin
    logic [7:0] got;
    logic [7:0] exp_b;
    logic       stop_b;
    forever begin
      @(negedge clk);
      if (mon_en && tx_pin === 1'b0) begin
        mon_busy = 1'b1;
        starts.push_back(cyc);
        repeat (DIV / 2) @(negedge clk);
        n_checks++;
        if (tx_pin !== 1'b0) begin
          n_fail++;
          $display("FAIL start_bit: got %b want 0", tx_pin);
        end
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          got[i] = tx_pin;
        end
        exp_b = (exp_q.size() != 0) ? exp_q[0] : 8'hxx;
`ifdef USART_PARITY_EN
        repeat (DIV) @(negedge clk);
        n_checks++;
        if (tx_pin !== ^exp_b) begin
          n_fail++;
          $display("FAIL parity_bit: got %b want %b (byte %h)", tx_pin, ^exp_b, exp_b);
        end
`endif
        repeat (DIV) @(negedge clk);
        stop_b = tx_pin;
        n_checks++;
        if (stop_b !== 1'b1) begin
          n_fail++;
          $display("FAIL stop_bit: got %b want 1", stop_b);
        end
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL frame_data: got %h want none (unexpected frame)", got);
        end else begin
          exp_b = exp_q.pop_front();
          if (got !== exp_b) begin
            n_fail++;
            $display("FAIL frame_data: got %h want %h", got, exp_b);
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  // Called at a negedge; returns at the negedge right after the sampling edge.
  task automatic put(input logic [7:0] b);
    write = 1'b1;
    data_in = b;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while ((busy || mon_busy || exp_q.size() != 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k >= budget) begin
      n_fail++;
      $display("FAIL drain_timeout: busy=%b queued=%0d after %0d cycles", busy, exp_q.size(), k);
    end
  endtask

  task automatic test_reset;
    bit hi = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (tx_pin !== 1'b1)   begin n_fail++; $display("FAIL rst_tx: got %b want 1", tx_pin); end
    n_checks++; if (empty !== 1'b1)    begin n_fail++; $display("FAIL rst_empty: got %b want 1", empty); end
    n_checks++; if (full !== 1'b0)     begin n_fail++; $display("FAIL rst_full: got %b want 0", full); end
    n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b want 0", overflow); end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_pin !== 1'b1) hi = 1'b0;
    end
    n_checks++;
    if (!hi) begin n_fail++; $display("FAIL idle_high: got low want 1 for 100 cycles"); end
  endtask

  task automatic test_single;
    exp_q.push_back(8'h55);
    put(8'h55);
    n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL lat_empty: got %b want 0", empty); end
    @(negedge clk);
    n_checks++; if (tx_pin !== 1'b1) begin n_fail++; $display("FAIL lat_n1: got %b want 1", tx_pin); end
    @(negedge clk);
    n_checks++; if (tx_pin !== 1'b0) begin n_fail++; $display("FAIL lat_n2: got %b want 0", tx_pin); end
    repeat (FRAME - 2) @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_in_frame: got %b want 1", busy); end
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_end: got %b want 0", busy); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL empty_end: got %b want 1", empty); end
    wait_drain(200);
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes[4] = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    bit full_seen = 1'b0;
    int k = 0;
    starts.delete();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(bytes[i]);
      put(bytes[i]);
      if (full === 1'b1) full_seen = 1'b1;
    end
    while ((busy || mon_busy || exp_q.size() != 0) && k < 400) begin
      @(negedge clk);
      if (full === 1'b1) full_seen = 1'b1;
      k++;
    end
    n_checks++; if (k >= 400) begin n_fail++; $display("FAIL b2b_timeout: queued=%0d", exp_q.size()); end
    n_checks++; if (full_seen) begin n_fail++; $display("FAIL b2b_full: got 1 want 0"); end
    n_checks++;
    if (starts.size() != 4) begin
      n_fail++; $display("FAIL b2b_frames: got %0d want 4", starts.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        n_checks++;
        if (starts[i] - starts[i-1] != FRAME) begin
          n_fail++; $display("FAIL b2b_gap%0d: got %0d want %0d", i, starts[i] - starts[i-1], FRAME);
        end
      end
    end
  endtask

  task automatic test_overflow;
    for (int i = 1; i <= 5; i++) begin
      exp_q.push_back(8'(i));
      put(8'(i));
    end
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got %b want 1", full); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b want 0", overflow); end
    put(8'h06);
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", overflow); end
    clear_overflow = 1'b1;
    put(8'h77);
    clear_overflow = 1'b0;
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins: got %b want 1", overflow); end
    clear_overflow = 1'b1;
    @(negedge clk);
    clear_overflow = 1'b0;
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    wait_drain(600);
  endtask

  task automatic test_reset_midframe;
    mon_en = 1'b0;
    put(8'hF0);
    repeat (11) @(negedge clk);
    n_checks++; if (tx_pin !== 1'b0) begin n_fail++; $display("FAIL mid_frame_low: got %b want 0", tx_pin); end
    reset = 1'b1;
    #1;
    n_checks++; if (tx_pin !== 1'b1) begin n_fail++; $display("FAIL async_tx: got %b want 1", tx_pin); end
    n_checks++; if (empty !== 1'b1)  begin n_fail++; $display("FAIL async_empty: got %b want 1", empty); end
    n_checks++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL async_busy: got %b want 0", busy); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    exp_q.push_back(8'h0F);
    put(8'h0F);
    @(negedge clk);
    n_checks++; if (tx_pin !== 1'b1) begin n_fail++; $display("FAIL rel_lat_n1: got %b want 1", tx_pin); end
    @(negedge clk);
    n_checks++; if (tx_pin !== 1'b0) begin n_fail++; $display("FAIL rel_lat_n2: got %b want 0", tx_pin); end
    wait_drain(200);
  endtask

`ifdef USART_PARITY_EN
  task automatic test_parity;
    starts.delete();
    exp_q.push_back(8'h07);
    put(8'h07);
    exp_q.push_back(8'h03);
    put(8'h03);
    wait_drain(300);
    n_checks++;
    if (starts.size() != 2 || starts[1] - starts[0] != 44) begin
      n_fail++; $display("FAIL parity_frame_len: got %0d frames want 2 at 44 cycles apart", starts.size());
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    mon_en = 1'b1;
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_midframe();
`ifdef USART_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
